bus_sampler_ser: RTL and testbench

BUS_SAMPLER_SER -- requirements
Module: bus_sampler_ser

---
 rtl/bus_sampler_pkg.sv | 31 +++
 rtl/bus_sampler_if.sv | 11 +
 rtl/bus_sync_filter.sv | 70 +++++++
 rtl/bus_sampler_ser.sv | 152 +++++++++++++++
 tb/tb_bus_sampler_ser.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/bus_sampler_pkg.sv
// Shared types and constants for the bus sampler / serializer.
// BUS_SAMPLER_PARITY_EN adds an even-parity bit to every frame.
package bus_sampler_pkg;

    localparam int DEF_DATA_W = 8;

`ifdef BUS_SAMPLER_PARITY_EN
    localparam int PAR_BITS = 1;
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_e;
`else
    localparam int PAR_BITS = 0;
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
    } state_e;
`endif

    // start + data + optional parity + stop
    localparam int FRAME_BITS = DEF_DATA_W + 2 + PAR_BITS;

    function automatic int frame_bits(input int w);
        return w + 2 + PAR_BITS;
    endfunction

    // counter width with a floor of one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_sampler_if.sv
// Accept strobe and value handed from the filter to the serializer.
// The filter drives (master), the serializer consumes (slave).
interface bus_sampler_if #(
    parameter int DATA_W = 8
) ();
    logic              stb;
    logic [DATA_W-1:0] val;

    modport master (output stb, output val);
    modport slave  (input stb, input val);
endinterface

// File: rtl/bus_sync_filter.sv
// Two-flop synchronizer plus stability filter for the pad bus.
// Emits a one-cycle strobe when a new stable value is accepted.
module bus_sync_filter
    import bus_sampler_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STABLE_CNT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_a,
    bus_sampler_if.master     acc
);

    localparam int SW = $clog2(STABLE_CNT + 1);

    logic [DATA_W-1:0] s1_q, s2_q;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              stb_q, stb_d;

    // Count how long the synchronized value has held; accept when it
    // reaches the threshold and differs from the last accepted value.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        val_d  = val_q;
        stb_d  = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = SW'(1);
        end else if (cnt_q < SW'(STABLE_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == SW'(STABLE_CNT) && cand_d != last_q) begin
            stb_d  = 1'b1;
            val_d  = cand_d;
            last_d = cand_d;
        end
    end

    // Synchronizer and filter state; zero after reset so a zero bus
    // counts as already accepted.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cand_q <= '0;
            last_q <= '0;
            val_q  <= '0;
            cnt_q  <= '0;
            stb_q  <= 1'b0;
        end else begin
            s1_q   <= i_a;
            s2_q   <= s1_q;
            cand_q <= cand_d;
            last_q <= last_d;
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            stb_q  <= stb_d;
        end
    end

    assign acc.stb = stb_q;
    assign acc.val = val_q;

endmodule

// File: rtl/bus_sampler_ser.sv
// Samples an asynchronous bus and sends each new stable value as a
// serial frame. Define BUS_SAMPLER_PARITY_EN for an even-parity bit.
module bus_sampler_ser
    import bus_sampler_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STABLE_CNT = 4,
    parameter int BIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_a,
    output logic              o_a,
    output logic              o_busy,
    output logic              o_ovf
);

    localparam int BW = cnt_w(DATA_W);
    localparam int CW = cnt_w(BIT_CYCLES);

    bus_sampler_if #(.DATA_W(DATA_W)) acc_if ();

    bus_sync_filter #(
        .DATA_W    (DATA_W),
        .STABLE_CNT(STABLE_CNT)
    ) u_filt (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_a    (i_a),
        .acc    (acc_if)
    );

    state_e            state_q, state_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [CW-1:0]     cyc_q, cyc_d;
    logic [DATA_W-1:0] frm_q, frm_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic              ovf_q, ovf_d;

    logic              cyc_last;
    logic              bit_last;
    logic              have_next;
    logic              load;
    logic [DATA_W-1:0] next_val;

    assign cyc_last  = (cyc_q == CW'(BIT_CYCLES - 1));
    assign bit_last  = (bit_q == BW'(DATA_W - 1));
    assign have_next = acc_if.stb | pend_v_q;
    // the newest accepted value wins over an older pending one
    assign next_val  = acc_if.stb ? acc_if.val : pend_q;

    // State and datapath registers; reset aborts any frame.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            bit_q    <= '0;
            cyc_q    <= '0;
            frm_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            frm_q    <= frm_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state: advance one frame bit per BIT_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (have_next) state_d = START;
            end
            START: begin
                if (cyc_last) state_d = DATA;
            end
            DATA: begin
                if (cyc_last && bit_last) begin
`ifdef BUS_SAMPLER_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef BUS_SAMPLER_PARITY_EN
            PARITY: begin
                if (cyc_last) state_d = STOP;
            end
`endif
            STOP: begin
                if (cyc_last) state_d = have_next ? START : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counters, frame capture and one-deep pending buffer.
    always_comb begin
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        frm_d    = frm_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ovf_d    = 1'b0;
        load     = have_next &&
                   (state_q == IDLE || (state_q == STOP && cyc_last));
        if (state_q == IDLE) begin
            cyc_d = '0;
        end else begin
            cyc_d = cyc_last ? '0 : cyc_q + 1'b1;
        end
        if (state_q == DATA && cyc_last) begin
            bit_d = bit_last ? '0 : bit_q + 1'b1;
        end
        if (load) begin
            frm_d    = next_val;
            pend_v_d = 1'b0;
            ovf_d    = acc_if.stb & pend_v_q;
        end else if (acc_if.stb && state_q != IDLE) begin
            pend_d   = acc_if.val;
            pend_v_d = 1'b1;
            ovf_d    = pend_v_q;
        end
    end

    // Line level for the current frame bit; idles high.
    always_comb begin
        o_a = 1'b1;
        unique case (state_q)
            IDLE:   o_a = 1'b1;
            START:  o_a = 1'b0;
            DATA:   o_a = frm_q[bit_q];
`ifdef BUS_SAMPLER_PARITY_EN
            PARITY: o_a = ^frm_q;
`endif
            STOP:   o_a = 1'b1;
            default: o_a = 1'b1;
        endcase
    end

    assign o_busy = (state_q != IDLE);
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_bus_sampler_ser.sv
// Directed bench for bus_sampler_ser: idle, frame timing, glitch
// rejection, pending overwrite and mid-frame reset.
module tb_bus_sampler_ser;

    localparam int DW = 8;
`ifdef BUS_SAMPLER_PARITY_EN
    localparam int NB  = DW + 3;
    localparam bit PAR = 1'b1;
`else
    localparam int NB  = DW + 2;
    localparam bit PAR = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] i_a   = '0;
    logic          o_a;
    logic          o_busy;
    logic          o_ovf;

    int   n_chk = 0;
    int   n_err = 0;
    int   busy_cnt;
    int   ovf_cnt;
    int   low_cnt;
    logic oa_log [0:99];

    always #5 clk = ~clk;

    bus_sampler_ser #(
        .DATA_W    (DW),
        .STABLE_CNT(4),
        .BIT_CYCLES(2)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_a    (i_a),
        .o_a    (o_a),
        .o_busy (o_busy),
        .o_ovf  (o_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [DW-1:0] v,
                                     input int i);
        if (i == 0) return 1'b0;
        if (i <= DW) return v[i-1];
        if (PAR && i == DW + 1) return ^v;
        return 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_a   = '0;
        repeat (3) @(negedge clk);
        chk("rst_oa", o_a, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovf", o_ovf, 0);
        rst_n = 1'b1;
    endtask

    // log n cycles; optionally change i_a after cycles ka and kb
    task automatic capture(input int n,
                           input int ka, input logic [DW-1:0] va,
                           input int kb, input logic [DW-1:0] vb);
        busy_cnt = 0;
        ovf_cnt  = 0;
        low_cnt  = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            oa_log[k] = o_a;
            busy_cnt += int'(o_busy);
            ovf_cnt  += int'(o_ovf);
            low_cnt  += int'(!o_a);
            if (k == ka) i_a = va;
            if (k == kb) i_a = vb;
        end
    endtask

    task automatic check_frame(input string tag,
                               input logic [DW-1:0] v, input int k0);
        for (int i = 0; i < NB; i++) begin
            logic e;
            e = exp_bit(v, i);
            chk($sformatf("%s_bit%0d", tag, i),
                {oa_log[k0+2*i], oa_log[k0+2*i+1]}, {e, e});
        end
    endtask

    initial begin
        do_reset();

        // constant zero bus: nothing sent
        capture(50, 0, '0, 0, '0);
        chk("zero_busy", busy_cnt, 0);
        chk("zero_low", low_cnt, 0);
        chk("zero_ovf", ovf_cnt, 0);

        // single value: start bit seven edges after first sample
        i_a = 8'hA5;
        capture(40, 0, '0, 0, '0);
        chk("a5_pre", oa_log[6], 1);
        check_frame("a5", 8'hA5, 7);
        chk("a5_after", oa_log[7+2*NB], 1);
        chk("a5_busy", busy_cnt, 2 * NB);
        chk("a5_ovf", ovf_cnt, 0);

        // short glitch back to the accepted value: no frame
        do_reset();
        i_a = 8'hFF;
        capture(40, 3, 8'h00, 0, '0);
        chk("glitch_busy", busy_cnt, 0);
        chk("glitch_low", low_cnt, 0);

        // 01 sent, 02 pending then overwritten by 03, 03 back-to-back
        i_a = 8'h01;
        capture(70, 10, 8'h02, 17, 8'h03);
        chk("ovf_cnt", ovf_cnt, 1);
        check_frame("f01", 8'h01, 7);
        check_frame("f03", 8'h03, 7 + 2*NB);
        chk("b2b_busy", busy_cnt, 4 * NB);
        chk("b2b_after", oa_log[7+4*NB], 1);

        // reset during data bit 4 of 3C aborts the frame
        i_a = 8'h3C;
        capture(17, 0, '0, 0, '0);
        chk("3c_bit4", oa_log[17], 1);
        chk("3c_busy_pre", busy_cnt, 11);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_oa", o_a, 1);
        chk("abort_busy", o_busy, 0);
        repeat (2) @(negedge clk);
        chk("abort_busy2", o_busy, 0);
        rst_n = 1'b1;
        capture(40, 0, '0, 0, '0);
        check_frame("r3c", 8'h3C, 7);
        chk("r3c_busy", busy_cnt, 2 * NB);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
